// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: op codes, FSM states and op classification helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;
  typedef enum logic [3:0] {
    LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4,
    SB = 4'd5, SH = 4'd6, SW = 4'd7, LL = 4'd8, SC = 4'd9
  } op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;
  localparam logic WRITE = 1'b1;
  localparam logic READ = 1'b0;
  function automatic logic is_load(op_e o);
    return o inside {LB, LBU, LH, LHU, LW, LL};
  endfunction
  function automatic logic is_store(op_e o);
    return o inside {SB, SH, SW, SC};
  endfunction
  function automatic logic is_half(op_e o);
    return o inside {LH, LHU, SH};
  endfunction
  function automatic logic is_word(op_e o);
    return o inside {LW, LL, SW, SC};
  endfunction
endpackage

// File: rtl/mem_lsu_load_fmt.sv
// lsu_load_fmt: big-endian byte/halfword select with sign or zero extension of RAM read data.
module lsu_load_fmt
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_e               op,
  input  logic [1:0]        a,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = a == 2'd0 ? rdata[31:24] : a == 2'd1 ? rdata[23:16] : a == 2'd2 ? rdata[15:8] : rdata[7:0];
    h = a[1] ? rdata[15:0] : rdata[31:16];
    data = op == LB  ? {{(DATA_W-8){b[7]}}, b} :
           op == LBU ? {{(DATA_W-8){1'b0}}, b} :
           op == LH  ? {{(DATA_W-16){h[15]}}, h} :
           op == LHU ? {{(DATA_W-16){1'b0}}, h} : rdata;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving the data RAM, with LL/SC link tracking,
// alignment exceptions and a pipeline stall held for the length of each access.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_wd,
  input  logic              req_wreg,
  input  logic              flush,
  output logic              ram_en,
  output logic              wr_en,
  output logic [3:0]        Bits_Sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_to_ram,
  input  logic [DATA_W-1:0] data_from_ram,
  output logic              stall_req,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_wdata,
  output logic [4:0]        resp_wd,
  output logic              resp_wreg,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] bad_vaddr
);
  state_e state;
  op_e op, new_op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata, ld_data;
  logic [4:0] wd;
  logic wreg, exc, sc_ok, link;
  logic [ADDR_W-3:0] link_addr;
  logic take, mis, ld, st, sc_pass, acc;
  assign new_op = op_e'(req_op);
  assign take = state == IDLE && req_valid && !flush;
  assign mis = is_half(new_op) ? req_addr[0] : is_word(new_op) ? |req_addr[1:0] : 1'b0;
  assign ld = is_load(op);
  assign st = is_store(op);
  assign sc_pass = link && link_addr == addr[ADDR_W-1:2];
  assign acc = state == ACCESS && !flush;
  lsu_load_fmt #(.DATA_W(DATA_W)) u_fmt (.op(op), .a(addr[1:0]), .rdata(rdata), .data(ld_data));
  // A failed SC never reaches the RAM, so every RAM control is qualified by ram_en.
  always_comb begin
    ram_en = acc && (ld || st) && !(op == SC && !sc_pass);
    wr_en = ram_en && st ? WRITE : READ;
    Bits_Sel = !ram_en ? 4'b0000 :
               ld || op == SW || op == SC ? 4'b1111 :
               op == SH ? (addr[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> addr[1:0];
    ram_addr = ram_en ? {addr[ADDR_W-1:2], 2'b00} : '0;
    data_to_ram = !wr_en ? '0 : op == SB ? {4{wdata[7:0]}} : op == SH ? {2{wdata[15:0]}} : wdata;
    stall_req = take || state == ACCESS;
    resp_valid = state == DONE && !flush;
    resp_wdata = !resp_valid || exc ? '0 : ld ? ld_data : op == SC ? DATA_W'(sc_ok) : '0;
    resp_wd = resp_valid ? wd : 5'd0;
    resp_wreg = resp_valid && wreg && !exc;
    exc_adel = resp_valid && exc && ld;
    exc_ades = resp_valid && exc && st;
    bad_vaddr = resp_valid && exc ? addr : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= LB;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      wd <= 5'd0;
      wreg <= 1'b0;
      exc <= 1'b0;
      sc_ok <= 1'b0;
      link <= 1'b0;
      link_addr <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          op <= new_op;
          addr <= req_addr;
          wdata <= req_wdata;
          wd <= req_wd;
          wreg <= req_wreg;
          exc <= mis;
          state <= mis ? DONE : ACCESS;
        end
        ACCESS: begin
          rdata <= data_from_ram;
          sc_ok <= op == SC && sc_pass;
          state <= flush ? IDLE : DONE;
          if (op == LL) begin
            link <= 1'b1;
            link_addr <= addr[ADDR_W-1:2];
          end else if (op == SC || (st && addr[ADDR_W-1:2] == link_addr)) link <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (flush) link <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vector table, reset-abort sequence and randomized ops checked
// against a byte-array memory model with an LL/SC link flag.
module tb_mem_lsu;
  import mem_lsu_pkg::*;
  logic clk = 0, rst_n = 0, req_valid = 0, req_wreg = 0, flush = 0, clr = 1;
  logic [3:0] req_op = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [4:0] req_wd = 0;
  logic ram_en, wr_en, stall_req, resp_valid, resp_wreg, exc_adel, exc_ades;
  logic [3:0] Bits_Sel;
  logic [31:0] ram_addr, data_to_ram, data_from_ram, resp_wdata, bad_vaddr;
  logic [4:0] resp_wd;
  logic [31:0] ram [64];
  int tests = 0, fails = 0;

  typedef struct {
    logic [3:0] op; logic [31:0] a, d; bit fl; logic [4:0] wd; bit wreg;
    bit en, wr; logic [3:0] bsel; logic [31:0] dtr, rd; int lat; bit adel, ades;
  } vec_t;
  typedef struct {
    int lat, nresp; bit en, wr, st1, st_resp, adel, ades, wreg;
    logic [3:0] bsel; logic [31:0] dtr, addr, rd, bad; logic [4:0] wd;
  } txn_t;

  logic [7:0] ref_bytes [256];
  bit ref_link = 0;
  logic [31:0] ref_wa = 0;

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wd(req_wd), .req_wreg(req_wreg), .flush(flush),
    .ram_en(ram_en), .wr_en(wr_en), .Bits_Sel(Bits_Sel), .ram_addr(ram_addr),
    .data_to_ram(data_to_ram), .data_from_ram(data_from_ram), .stall_req(stall_req),
    .resp_valid(resp_valid), .resp_wdata(resp_wdata), .resp_wd(resp_wd), .resp_wreg(resp_wreg),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;
  assign data_from_ram = ram[ram_addr[7:2]];
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 64; i++) ram[i] <= '0;
    else if (ram_en && wr_en)
      for (int i = 0; i < 4; i++) if (Bits_Sel[i]) ram[ram_addr[7:2]][8*i +: 8] <= data_to_ram[8*i +: 8];
  end

  task automatic chk(input string nm, input string f, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s %s: got %h expected %h", nm, f, got, exp);
    end
  endtask

  function automatic bit misal(logic [3:0] op, logic [31:0] a);
    return op inside {LH, LHU, SH} ? a[0] : op inside {LW, LL, SW, SC} ? a[1:0] != 2'b00 : 1'b0;
  endfunction

  function automatic vec_t mk(logic [3:0] op, logic [31:0] a, d, bit fl, en, wr, logic [3:0] bsel,
                              logic [31:0] dtr, rd, int lat, bit adel, ades);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.fl = fl; v.wd = 0; v.wreg = 1;
    v.en = en; v.wr = wr; v.bsel = bsel; v.dtr = dtr; v.rd = rd; v.lat = lat; v.adel = adel; v.ades = ades;
    return v;
  endfunction

  // Memory is a plain byte array; byte address a holds the most significant byte of a word.
  task automatic model(input vec_t v, output vec_t e);
    int n, k;
    logic [31:0] val;
    bit ld, ok;
    e = v; e.en = 0; e.wr = 0; e.bsel = 0; e.dtr = 0; e.rd = 0; e.lat = 2; e.adel = 0; e.ades = 0;
    ld = v.op inside {LB, LBU, LH, LHU, LW, LL};
    n = v.op inside {LB, LBU, SB} ? 1 : v.op inside {LH, LHU, SH} ? 2 : 4;
    if (v.fl) begin
      e.lat = 0; ref_link = 0;
    end else if (misal(v.op, v.a)) begin
      e.lat = 1; e.adel = ld; e.ades = !ld;
    end else if (ld) begin
      val = 0;
      for (int i = 0; i < n; i++) val = (val << 8) | 32'(ref_bytes[8'(v.a + i)]);
      e.en = 1; e.bsel = 4'hF;
      e.rd = v.op == LB ? {{24{val[7]}}, val[7:0]} : v.op == LH ? {{16{val[15]}}, val[15:0]} : val;
      if (v.op == LL) begin ref_link = 1; ref_wa = v.a >> 2; end
    end else begin
      ok = v.op != SC || (ref_link && ref_wa == v.a >> 2);
      if (ok) begin
        e.en = 1; e.wr = 1;
        e.dtr = n == 1 ? {4{v.d[7:0]}} : n == 2 ? {2{v.d[15:0]}} : v.d;
        for (int i = 0; i < n; i++) begin
          ref_bytes[8'(v.a + i)] = 8'(v.d >> (8 * (n - 1 - i)));
          k = 3 - int'((v.a + i) & 3);
          e.bsel[k] = 1'b1;
        end
      end
      if (v.op == SC) begin e.rd = 32'(ok); ref_link = 0; end
      else if (ref_wa == v.a >> 2) ref_link = 0;
    end
  endtask

  task automatic run(input vec_t v, output txn_t r);
    r = '{default: 0};
    @(negedge clk);
    req_valid = 1; req_op = v.op; req_addr = v.a; req_wdata = v.d; req_wd = v.wd; req_wreg = v.wreg;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 0;
      flush = v.fl && c == 1;
      #1;
      if (c == 1) r.st1 = stall_req;
      if (ram_en && !r.en) begin
        r.en = 1; r.wr = wr_en; r.bsel = Bits_Sel; r.dtr = data_to_ram; r.addr = ram_addr;
      end
      if (resp_valid) begin
        r.nresp++;
        if (r.lat == 0) begin
          r.lat = c; r.rd = resp_wdata; r.adel = exc_adel; r.ades = exc_ades; r.wreg = resp_wreg;
          r.wd = resp_wd; r.bad = bad_vaddr; r.st_resp = stall_req;
        end
      end
    end
    flush = 0;
  endtask

  task automatic cmp(input string nm, input vec_t e, input txn_t r);
    chk(nm, "latency", r.lat, e.lat);
    chk(nm, "resp_count", r.nresp, e.lat != 0);
    chk(nm, "ram_en", r.en, e.en);
    chk(nm, "stall", r.st1, !misal(e.op, e.a));
    if (e.en && r.en) begin
      chk(nm, "Bits_Sel", r.bsel, e.bsel);
      chk(nm, "wr_en", r.wr, e.wr);
      chk(nm, "ram_addr", r.addr, e.a & ~32'd3);
      if (e.wr) chk(nm, "data_to_ram", r.dtr, e.dtr);
    end
    if (e.lat != 0 && r.lat != 0) begin
      chk(nm, "resp_wdata", r.rd, e.rd);
      chk(nm, "exc_adel", r.adel, e.adel);
      chk(nm, "exc_ades", r.ades, e.ades);
      chk(nm, "resp_wreg", r.wreg, e.wreg && !(e.adel || e.ades));
      chk(nm, "resp_wd", r.wd, e.wd);
      chk(nm, "stall_in_done", r.st_resp, 0);
      if (e.adel || e.ades) chk(nm, "bad_vaddr", r.bad, e.a);
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v, e;
    txn_t r;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 0;
    tbl.push_back(mk(SW,  'h10, 'hDEADBEEF, 0, 1, 1, 4'hF, 'hDEADBEEF, 0, 2, 0, 0));
    tbl.push_back(mk(LW,  'h10, 0,          0, 1, 0, 4'hF, 0, 'hDEADBEEF, 2, 0, 0));
    tbl.push_back(mk(SB,  'h13, 'hAA,       0, 1, 1, 4'h1, 'hAAAAAAAA, 0, 2, 0, 0));
    tbl.push_back(mk(LB,  'h13, 0,          0, 1, 0, 4'hF, 0, 'hFFFFFFAA, 2, 0, 0));
    tbl.push_back(mk(LBU, 'h13, 0,          0, 1, 0, 4'hF, 0, 'h000000AA, 2, 0, 0));
    tbl.push_back(mk(SH,  'h12, 'h1234,     0, 1, 1, 4'h3, 'h12341234, 0, 2, 0, 0));
    tbl.push_back(mk(LHU, 'h12, 0,          0, 1, 0, 4'hF, 0, 'h00001234, 2, 0, 0));
    tbl.push_back(mk(LH,  'h10, 0,          0, 1, 0, 4'hF, 0, 'hFFFFDEAD, 2, 0, 0));
    tbl.push_back(mk(SB,  'h10, 'h7F,       0, 1, 1, 4'h8, 'h7F7F7F7F, 0, 2, 0, 0));
    tbl.push_back(mk(LBU, 'h11, 0,          0, 1, 0, 4'hF, 0, 'h000000AD, 2, 0, 0));
    tbl.push_back(mk(LB,  'h10, 0,          0, 1, 0, 4'hF, 0, 'h0000007F, 2, 0, 0));
    tbl.push_back(mk(LH,  'h11, 0,          0, 0, 0, 4'h0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(SW,  'h12, 'h55,       0, 0, 0, 4'h0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(LL,  'h20, 0,          0, 1, 0, 4'hF, 0, 0, 2, 0, 0));
    tbl.push_back(mk(SC,  'h20, 5,          0, 1, 1, 4'hF, 5, 1, 2, 0, 0));
    tbl.push_back(mk(LW,  'h20, 0,          0, 1, 0, 4'hF, 0, 5, 2, 0, 0));
    tbl.push_back(mk(SC,  'h20, 7,          0, 0, 0, 4'h0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(LL,  'h20, 0,          0, 1, 0, 4'hF, 0, 5, 2, 0, 0));
    tbl.push_back(mk(SW,  'h20, 9,          0, 1, 1, 4'hF, 9, 0, 2, 0, 0));
    tbl.push_back(mk(SC,  'h20, 'hA,        0, 0, 0, 4'h0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(LW,  'h20, 0,          0, 1, 0, 4'hF, 0, 9, 2, 0, 0));
    tbl.push_back(mk(SW,  'h24, 'h11111111, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(LW,  'h24, 0,          0, 1, 0, 4'hF, 0, 0, 2, 0, 0));

    repeat (2) @(negedge clk);
    chk("reset", "ram_en", ram_en, 0);
    chk("reset", "stall_req", stall_req, 0);
    chk("reset", "resp_valid", resp_valid, 0);
    chk("reset", "outputs", {Bits_Sel, wr_en, resp_wreg, exc_adel, exc_ades}, 0);
    chk("reset", "resp_wdata", resp_wdata, 0);
    rst_n = 1; clr = 0;

    foreach (tbl[i]) begin
      v = tbl[i];
      v.wd = 5'(i);
      model(v, e);
      run(v, r);
      cmp($sformatf("vec%0d", i), v, r);
    end

    // Reset while an LW is in ACCESS must drop everything at once and forget the link.
    v = mk(LL, 'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model(v, e);
    run(v, r);
    cmp("ll_before_reset", e, r);
    @(negedge clk);
    req_valid = 1; req_op = LW; req_addr = 'h24; req_wd = 3; req_wreg = 1;
    @(negedge clk);
    req_valid = 0;
    #1 chk("rst_mid", "ram_en_before", ram_en, 1);
    #1 rst_n = 0;
    #1 chk("rst_mid", "ram_en", ram_en, 0);
    chk("rst_mid", "stall_req", stall_req, 0);
    chk("rst_mid", "resp_valid", resp_valid, 0);
    ref_link = 0;
    @(negedge clk);
    chk("rst_mid", "resp_after_edge", {resp_valid, stall_req, ram_en}, 0);
    rst_n = 1;
    v = mk(SC, 'h20, 'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model(v, e);
    run(v, r);
    cmp("sc_after_reset", e, r);
    chk("sc_after_reset", "no_write", r.en, 0);

    for (int n = 0; n < 300; n++) begin
      v = mk(4'($urandom_range(0, 9)), 32'($urandom_range(0, 47)), $urandom, $urandom_range(0, 9) == 0,
             0, 0, 0, 0, 0, 0, 0, 0);
      if ($urandom_range(0, 3) != 0) v.a[1:0] = 2'b00;
      v.wd = 5'($urandom);
      v.wreg = 1'($urandom);
      model(v, e);
      run(v, r);
      cmp($sformatf("rnd%0d", n), e, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage MIPS pipeline.
- Sits directly upstream of the data RAM, between the EX/MEM register and the RAM.
- Turns a decoded memory op into the RAM's ram_en / wr_en / Bits_Sel / address / write-data controls.
- Formats load data with sign or zero extension, tracks the LL/SC link bit, flags misaligned accesses, and stalls the pipeline for the duration of an access.

Parameters:
- DATA_W, 32, data and RAM word width.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory op present from EX/MEM.
- req_op  in  4  op code from the shared package.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  DATA_W  store source register value.
- req_wd  in  5  destination register index.
- req_wreg  in  1  destination write enable.
- flush  in  1  pipeline flush, synchronous.
- ram_en  out  1  RAM enable.
- wr_en  out  1  RAM write, 1 = WRITE.
- Bits_Sel  out  4  byte-lane enables; bit3 = data[31:24].
- ram_addr  out  ADDR_W  byte address, word aligned (addr[1:0] = 0).
- data_to_ram  out  DATA_W  lane-replicated store data.
- data_from_ram  in  DATA_W  combinational RAM read data.
- stall_req  out  1  hold IF..EX.
- resp_valid  out  1  one-cycle result strobe to MEM/WB.
- resp_wdata  out  DATA_W  load / SC result.
- resp_wd  out  5  registered req_wd.
- resp_wreg  out  1  registered req_wreg, forced 0 on exception.
- exc_adel  out  1  load address error.
- exc_ades  out  1  store address error.
- bad_vaddr  out  ADDR_W  faulting address.

Behaviour:
- Reset (rst_n = 0, takes effect immediately):
  - state = IDLE, link = 0, link_addr = 0.
  - All outputs 0.
  - Reset asserted mid-access aborts the access; no RAM write is guaranteed.
- Endianness is big-endian. Byte at addr[1:0]=00 uses lane 3 (Bits_Sel 1000), 11 uses lane 0 (0001). Halfword at addr[1]=0 uses 1100, addr[1]=1 uses 0011.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On req_valid && !flush, latch op, addr, wdata, wd and wreg, and check alignment.
  - Half access needs addr[0]=0. Word access (LW/LL/SW/SC) needs addr[1:0]=0.
  - Misaligned: go to DONE with the exception flag pending; ram_en stays 0.
  - Aligned: go to ACCESS.
- ACCESS (exactly one cycle):
  - ram_en = 1, ram_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Load: wr_en = 0, Bits_Sel = 1111; capture data_from_ram into rdata at the clock edge.
  - Store: wr_en = 1 with Bits_Sel per the lane map. data_to_ram = {4{b}} for SB, {2{h}} for SH, raw word for SW/SC.
  - SC with link=0 or link_addr != addr[31:2]: ram_en = 0 (no write), result = 0. Otherwise write, result = 1.
  - flush in ACCESS gates ram_en to 0 combinationally; next state IDLE, no resp_valid.
  - Otherwise next state DONE.
- DONE (one cycle):
  - resp_valid = 1 unless flush.
  - resp_wdata for loads:
    - LB/LH: sign-extended selected byte or halfword.
    - LBU/LHU: zero-extended.
    - LW/LL: rdata.
  - resp_wdata for SC: {31'b0, success}. Other stores: 0.
  - On exception: exc_adel or exc_ades = 1, bad_vaddr = addr, resp_wreg = 0.
  - Next state IDLE.
- stall_req = (state==IDLE && req_valid && !flush) || state==ACCESS. It is low in DONE so the pipeline advances with the result.
- Latency: request to resp_valid is 2 cycles (1 cycle on exception). Throughput is one op per 3 cycles.
- Link bit:
  - Successful LL sets link = 1 and link_addr = addr[31:2].
  - Any SC clears link.
  - SW/SH/SB to link_addr clears link.
  - flush clears link.
  - Simultaneous LL set and flush: flush wins.
- RAM control outputs are 0 in every state except ACCESS.

Decomposition:
- Shared package/define file holds:
  - Op codes: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7, LL=8, SC=9.
  - WRITE=1 and READ=0.
  - FSM state encodings IDLE=0, ACCESS=1, DONE=2.
- One natural sub-module: lsu_load_fmt, a combinational byte/half select plus extend, taking op, addr[1:0] and rdata.

Test Plan:
1. SW 0x10 data 0xDEADBEEF, then LW 0x10 -> ACCESS shows Bits_Sel 1111 with wr_en 1 then 0; resp_wdata 0xDEADBEEF exactly 2 cycles after the LW request.
2. SB 0x13 data 0x000000AA -> Bits_Sel 0001, data_to_ram 0xAAAAAAAA; LB 0x13 -> 0xFFFFFFAA; LBU 0x13 -> 0x000000AA; SH 0x12 data 0x1234 then LHU 0x12 -> 0x00001234.
3. LH 0x11 -> ram_en never 1, exc_adel 1, bad_vaddr 0x11, resp_wreg 0, resp 1 cycle after request; SW 0x12 -> exc_ades 1.
4. LL 0x20, then SC 0x20 data 5 -> write occurs, result 1, word reads back 5; second SC 0x20 -> ram_en 0, result 0.
5. LL 0x20, SW 0x20, SC 0x20 -> SC fails with result 0; flush asserted during SW ACCESS -> ram_en 0, no resp_valid, memory unchanged.
6. rst_n dropped during ACCESS -> ram_en, stall_req and resp_valid go 0 without waiting for a clock edge; after release, state IDLE, link 0, SC fails.
